// File: rtl/slc3_ctrl_pkg.sv
// slc3_ctrl_pkg: shared definitions for the SLC-3 control unit.
//   - opcode constants (IR[15:12])
//   - alu_op_t: ALUK encodings
//   - PCMUX / ADDR2MUX encodings
//   - state_t: control FSM states
// Build option: SLC3_PAUSE_EN adds the PAUSE opcode and states P1/P2.
package slc3_ctrl_pkg;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_t;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_S18,
    ST_RD,
    ST_S35,
    ST_S32,
    ST_S01,
    ST_S05,
    ST_S09,
    ST_S00,
    ST_S22,
    ST_S12,
    ST_S04,
    ST_S21,
    ST_S20,
    ST_S06,
    ST_S27,
    ST_S07,
    ST_S23,
    ST_WR
`ifdef SLC3_PAUSE_EN
    ,
    ST_P1,
    ST_P2
`endif
  } state_t;

endpackage

// File: rtl/slc3_mem_wait_timer.sv
// slc3_mem_wait_timer: SRAM access wait counter.
//   Clk   in  system clock
//   Reset in  asynchronous, active-high reset
//   load  in  1 = hold the counter at its reload value (outside a memory access)
//   done  out 1 = this is the last cycle of the current access
// While load is low the counter walks from WAIT-1 down to zero and parks there,
// so an access lasts exactly WAIT cycles.
module slc3_mem_wait_timer #(
  parameter int unsigned WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  output logic done
);

  localparam int unsigned CW = (WAIT > 1) ? $clog2(WAIT + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= RELOAD;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/slc3_control_fsm.sv
// slc3_control_fsm: SLC-3 control unit, Moore FSM between IR/NZP logic and datapath.
//   Clk, Reset (async, active-high)
//   Run, Continue               start from HALTED / resume from PAUSE
//   BEN, Opcode, IR_5, IR_11    decode inputs
//   LD_*                        register load enables
//   Gate*                       bus drivers (one-hot or none)
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK   datapath selects
//   Mem_OE, Mem_WE              SRAM strobes, active-low
// Parameter MEM_WAIT (1..15): cycles each SRAM strobe is held low.
// Build option: SLC3_PAUSE_EN enables the PAUSE opcode (P1/P2 states);
// without it PAUSE decodes as a NOP.
module slc3_control_fsm
  import slc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic       BEN,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_t  state, next_state;
  state_t  rd_return;   // where RD goes when the read completes
  alu_op_t alu_sel;
  logic    mem_active, mem_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_HALTED;
    else       state <= next_state;
  end

  // RD is shared by instruction fetch and LDR; remember who entered it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                  rd_return <= ST_S35;
    else if (state == ST_S18)   rd_return <= ST_S35;
    else if (state == ST_S06)   rd_return <= ST_S27;
  end

  // The timer is held at reload outside RD/WR, so each access starts fresh.
  assign mem_active = (state == ST_RD) || (state == ST_WR);

  slc3_mem_wait_timer #(
    .WAIT (MEM_WAIT)
  ) u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (!mem_active),
    .done  (mem_done)
  );

`ifndef SLC3_PAUSE_EN
  // Continue only matters when the pause feature is built in.
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_comb begin
    // NOTE: every output gets its idle value first, so no path through the
    // case can leave one unassigned and infer a latch.
    next_state = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    alu_sel    = ALU_ADD;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    case (state)
      ST_HALTED: if (Run) next_state = ST_S18;

      ST_S18: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        LD_PC      = 1'b1;
        PCMUX      = PCMUX_INC;
        next_state = ST_RD;
      end

      ST_RD: begin
        Mem_OE = 1'b0;
        if (mem_done) begin
          LD_MDR     = 1'b1;
          next_state = rd_return;
        end
      end

      ST_S35: begin
        GateMDR    = 1'b1;
        LD_IR      = 1'b1;
        next_state = ST_S32;
      end

      ST_S32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   next_state = ST_S01;
          OP_AND:   next_state = ST_S05;
          OP_NOT:   next_state = ST_S09;
          OP_BR:    next_state = ST_S00;
          OP_JMP:   next_state = ST_S12;
          OP_JSR:   next_state = ST_S04;
          OP_LDR:   next_state = ST_S06;
          OP_STR:   next_state = ST_S07;
`ifdef SLC3_PAUSE_EN
          OP_PAUSE: next_state = ST_P1;
`endif
          default:  next_state = ST_S18;  // undefined opcodes run as NOP
        endcase
      end

      ST_S01, ST_S05: begin
        SR1MUX     = 1'b1;
        SR2MUX     = IR_5;
        alu_sel    = (state == ST_S05) ? ALU_AND : ALU_ADD;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = ST_S18;
      end

      ST_S09: begin
        SR1MUX     = 1'b1;
        alu_sel    = ALU_NOT;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = ST_S18;
      end

      ST_S00: next_state = BEN ? ST_S22 : ST_S18;

      ST_S22: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_OFF9;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        next_state = ST_S18;
      end

      // JMP and JSRR both route SR1 + 0 through the address adder into PC.
      ST_S12, ST_S20: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_ZERO;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        next_state = ST_S18;
      end

      ST_S04: begin
        GatePC     = 1'b1;
        DRMUX      = 1'b1;
        LD_REG     = 1'b1;
        next_state = IR_11 ? ST_S21 : ST_S20;
      end

      ST_S21: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_OFF11;
        PCMUX      = PCMUX_ADDER;
        LD_PC      = 1'b1;
        next_state = ST_S18;
      end

      // LDR and STR share the effective-address step.
      ST_S06, ST_S07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        next_state = (state == ST_S06) ? ST_RD : ST_S23;
      end

      ST_S27: begin
        GateMDR    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        next_state = ST_S18;
      end

      ST_S23: begin
        SR1MUX     = 1'b0;   // store source register lives in IR[11:9]
        alu_sel    = ALU_PASS;
        GateALU    = 1'b1;
        LD_MDR     = 1'b1;
        next_state = ST_WR;
      end

      ST_WR: begin
        Mem_WE = 1'b0;
        if (mem_done) next_state = ST_S18;
      end

`ifdef SLC3_PAUSE_EN
      // Two-step handshake: wait for the button press, then its release.
      ST_P1: if (Continue)  next_state = ST_P2;
      ST_P2: if (!Continue) next_state = ST_S18;
`endif

      default: next_state = ST_HALTED;
    endcase
  end

  assign ALUK = alu_sel;

endmodule

// File: tb/tb_slc3_control_fsm.sv
// tb_slc3_control_fsm: scoreboard bench for slc3_control_fsm.
// Two instances (MEM_WAIT = 2 and 4) share all inputs. Stimulus pushes
// {cycle, instance, expected state} entries; a monitor compares the
// instance's outputs against the expected control word at each falling edge.
module tb_slc3_control_fsm;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe, mem_we;
  } ctrl_t;

  typedef enum {
    E_HALT, E_S18, E_RD, E_RDL, E_S35, E_S32, E_ADDR, E_ADDI, E_ANDR, E_NOT,
    E_S00, E_S22, E_S12, E_S04, E_S21, E_S20, E_S06, E_S27, E_S23, E_WR
  } exp_e;

  typedef struct {
    int   cyc;
    int   inst;
    exp_e st;
  } sb_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       Continue = 1'b0;
  logic       BEN = 1'b0;
  logic       IR_5 = 1'b0;
  logic       IR_11 = 1'b0;
  logic [3:0] Opcode = 4'b0000;

  ctrl_t o2, o4;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;
  sb_t   sb[$];
  exp_e  tail[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  slc3_control_fsm #(.MEM_WAIT(2)) u_w2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .BEN(BEN),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11),
    .LD_MAR(o2.ld_mar), .LD_MDR(o2.ld_mdr), .LD_IR(o2.ld_ir), .LD_BEN(o2.ld_ben),
    .LD_CC(o2.ld_cc), .LD_REG(o2.ld_reg), .LD_PC(o2.ld_pc),
    .GatePC(o2.gate_pc), .GateMDR(o2.gate_mdr), .GateALU(o2.gate_alu),
    .GateMARMUX(o2.gate_marmux), .PCMUX(o2.pcmux), .DRMUX(o2.drmux),
    .SR1MUX(o2.sr1mux), .SR2MUX(o2.sr2mux), .ADDR1MUX(o2.addr1mux),
    .ADDR2MUX(o2.addr2mux), .ALUK(o2.aluk), .Mem_OE(o2.mem_oe), .Mem_WE(o2.mem_we)
  );

  slc3_control_fsm #(.MEM_WAIT(4)) u_w4 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .BEN(BEN),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11),
    .LD_MAR(o4.ld_mar), .LD_MDR(o4.ld_mdr), .LD_IR(o4.ld_ir), .LD_BEN(o4.ld_ben),
    .LD_CC(o4.ld_cc), .LD_REG(o4.ld_reg), .LD_PC(o4.ld_pc),
    .GatePC(o4.gate_pc), .GateMDR(o4.gate_mdr), .GateALU(o4.gate_alu),
    .GateMARMUX(o4.gate_marmux), .PCMUX(o4.pcmux), .DRMUX(o4.drmux),
    .SR1MUX(o4.sr1mux), .SR2MUX(o4.sr2mux), .ADDR1MUX(o4.addr1mux),
    .ADDR2MUX(o4.addr2mux), .ALUK(o4.aluk), .Mem_OE(o4.mem_oe), .Mem_WE(o4.mem_we)
  );

  // Expected control word for each state, straight from the state table.
  function automatic ctrl_t exp_out(input exp_e s);
    ctrl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    case (s)
      E_S18:  begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      E_RD:   c.mem_oe = 0;
      E_RDL:  begin c.mem_oe = 0; c.ld_mdr = 1; end
      E_S35:  begin c.gate_mdr = 1; c.ld_ir = 1; end
      E_S32:  c.ld_ben = 1;
      E_ADDR: begin c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_ADDI: begin c.sr1mux = 1; c.sr2mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_ANDR: begin c.sr1mux = 1; c.aluk = 2'b01; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_NOT:  begin c.sr1mux = 1; c.aluk = 2'b10; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_S22:  begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; end
      E_S12,
      E_S20:  begin c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1; end
      E_S04:  begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      E_S21:  begin c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1; end
      E_S06:  begin c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; end
      E_S27:  begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_S23:  begin c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; end
      E_WR:   c.mem_we = 0;
      default: ;  // E_HALT, E_S00: idle word
    endcase
    return c;
  endfunction

  // Monitor: consume every entry due at (or overdue by) the current cycle.
  initial begin
    sb_t   e;
    ctrl_t act, want;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e    = sb.pop_front();
        act  = (e.inst == 0) ? o2 : o4;
        want = exp_out(e.st);
        n_cmp++;
        if (e.cyc != cyc || act !== want) begin
          n_fail++;
          $display("FAIL %s inst%0d cyc %0d (at %0d): got %h want %h",
                   e.st.name(), e.inst, e.cyc, cyc, act, want);
        end
      end
    end
  end

  task automatic exp(input int inst, input int c, input exp_e s);
    sb_t e;
    e.cyc = c; e.inst = inst; e.st = s;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic reset_dut();
    @(negedge Clk);
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    idle(2);
    Reset = 1'b0;
  endtask

  // Raise Run; the next rising edge enters S18, which is cycle 'base'.
  task automatic kick(output int base);
    @(negedge Clk);
    Run  = 1'b1;
    base = cyc + 1;
  endtask

  task automatic unkick();
    @(negedge Clk);
    Run = 1'b0;
  endtask

  // Fetch: S18, RD x w (LD_MDR in the last), S35, S32; ex = first execute cycle.
  task automatic fetch(input int inst, input int base, input int w, output int ex);
    exp(inst, base, E_S18);
    for (int i = 0; i < w - 1; i++) exp(inst, base + 1 + i, E_RD);
    exp(inst, base + w,     E_RDL);
    exp(inst, base + w + 1, E_S35);
    exp(inst, base + w + 2, E_S32);
    ex = base + w + 3;
  endtask

  // One instruction on one instance; 'tail' lists the states after S32.
  task automatic run_prog(input int inst, input logic [3:0] op,
                          input logic i5, input logic i11, input logic ben);
    int b, e, w;
    reset_dut();
    Opcode = op; IR_5 = i5; IR_11 = i11; BEN = ben;
    w = (inst == 0) ? 2 : 4;
    kick(b);
    fetch(inst, b, w, e);
    foreach (tail[i]) exp(inst, e + i, tail[i]);
    unkick();
    idle(w + 6 + tail.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int b, e;

    // Reset state: both instances idle and stay HALTED with Run low.
    reset_dut();
    for (int i = 1; i <= 3; i++) begin
      exp(0, cyc + i, E_HALT);
      exp(1, cyc + i, E_HALT);
    end
    idle(4);

    // ADD imm: LD_MAR c1, OE low c2-3, LD_IR c4, LD_BEN c5, LD_REG/LD_CC c6.
    tail = {E_ADDI, E_S18};          run_prog(0, 4'b0001, 1'b1, 1'b0, 1'b0);
    tail = {E_ADDR, E_S18};          run_prog(0, 4'b0001, 1'b0, 1'b0, 1'b0);
    tail = {E_ANDR, E_S18};          run_prog(0, 4'b0101, 1'b0, 1'b0, 1'b0);
    tail = {E_NOT, E_S18};           run_prog(0, 4'b1001, 1'b0, 1'b0, 1'b0);
    tail = {E_S12, E_S18};           run_prog(0, 4'b1100, 1'b0, 1'b0, 1'b0);
    // BR not taken, then taken.
    tail = {E_S00, E_S18};           run_prog(0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tail = {E_S00, E_S22, E_S18};    run_prog(0, 4'b0000, 1'b0, 1'b0, 1'b1);
    // JSR (offset) and JSRR (register).
    tail = {E_S04, E_S21, E_S18};    run_prog(0, 4'b0100, 1'b0, 1'b1, 1'b0);
    tail = {E_S04, E_S20, E_S18};    run_prog(0, 4'b0100, 1'b0, 1'b0, 1'b0);
    // LDR: RD must return to S27, on both wait settings.
    tail = {E_S06, E_RD, E_RDL, E_S27, E_S18};
    run_prog(0, 4'b0110, 1'b0, 1'b0, 1'b0);
    tail = {E_S06, E_RD, E_RD, E_RD, E_RDL, E_S27, E_S18};
    run_prog(1, 4'b0110, 1'b0, 1'b0, 1'b0);
    // STR with MEM_WAIT=4: WE low exactly 4 cycles, then S18.
    tail = {E_S06, E_S23, E_WR, E_WR, E_WR, E_WR, E_S18};
    run_prog(1, 4'b0111, 1'b0, 1'b0, 1'b0);
    // Undefined opcodes behave as NOP and refetch.
    tail = {E_S18, E_RD};            run_prog(0, 4'b1010, 1'b0, 1'b0, 1'b0);
    tail = {E_S18, E_RD};            run_prog(0, 4'b1111, 1'b0, 1'b0, 1'b0);

`ifdef SLC3_PAUSE_EN
    // PAUSE: idle in P1 for 10 cycles, Continue press -> P2, release -> S18.
    reset_dut();
    Opcode = 4'b1101;
    kick(b);
    fetch(0, b, 2, e);
    for (int i = 0; i < 12; i++) exp(0, e + i, E_HALT);
    exp(0, e + 12, E_S18);
    exp(0, e + 13, E_RD);
    unkick();
    while (cyc < e + 9) @(negedge Clk);
    Continue = 1'b1;
    while (cyc < e + 11) @(negedge Clk);
    Continue = 1'b0;
    idle(4);
`else
    tail = {E_S18, E_RD};            run_prog(0, 4'b1101, 1'b0, 1'b0, 1'b0);
`endif

    // Reset asserted during RD: outputs drop to idle within that cycle.
    reset_dut();
    Opcode = 4'b0001;
    kick(b);
    exp(0, b, E_S18);
    exp(1, b, E_S18);
    exp(0, b + 1, E_HALT);
    exp(1, b + 1, E_HALT);
    exp(0, b + 2, E_HALT);
    exp(0, b + 3, E_HALT);
    exp(1, b + 3, E_HALT);
    unkick();
    @(posedge Clk);
    #2 Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(3);

    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL pending: %0d expected entries never compared, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
